instr_fetch_unit: RTL and testbench

//  Holds the PC and fetches one instruction per step from instruction memory over a req/ack handshake.

---
 rtl/instr_fetch_unit.sv | 140 ++++++++++++++
 tb/tb_instr_fetch_unit.sv | 291 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/instr_fetch_unit.sv
// -----------------------------------------------------------------------------
// instr_fetch_unit
//   Holds the program counter and fetches one instruction per step from
//   instruction memory over a req/ack handshake. The fetched word and its
//   opcode go to the main control decoder. The next PC is chosen from the
//   decoder's jump/branch outputs and the ALU zero flag. pc_plus4 is exported
//   as the JAL link value.
//
//   Two-state control: FETCH (request outstanding) and EXEC (instruction held
//   until the datapath commits it with advance).
//
// Parameters
//   RESET_PC     PC loaded at reset (word aligned)
//   ACK_TIMEOUT  wait cycles tolerated without imem_ack; 0 = wait forever
//
// Ports
//   clk, rst_n               clock (rising edge), asynchronous active-low reset
//   imem_req/imem_addr       fetch request and byte address (= pc)
//   imem_ack/imem_rdata      memory response, accepted only while requesting
//   instr/opcode/instr_valid registered instruction, its opcode, valid flag
//   advance                  datapath commits the current instruction
//   branch/jump/zero/imm_ext next-PC selection inputs
//   pc/pc_plus4              current PC and its link value
//   fetch_err                sticky ack-timeout flag
//   instret_count            retired-instruction counter (optional)
//
// Configuration
//   IFU_INSTRET_CNT_EN  when defined, adds the instret_count output, counting
//                       every accepted advance (timeout NOPs included).
// -----------------------------------------------------------------------------
module instr_fetch_unit #(
    parameter logic [31:0] RESET_PC    = 32'h0000_0000,
    parameter int          ACK_TIMEOUT = 16
) (
    input  logic        clk,
    input  logic        rst_n,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ack,
    input  logic [31:0] imem_rdata,
    output logic [31:0] instr,
    output logic [5:0]  opcode,
    output logic        instr_valid,
    input  logic        advance,
    input  logic        branch,
    input  logic        jump,
    input  logic        zero,
    input  logic [31:0] imm_ext,
    output logic [31:0] pc,
    output logic [31:0] pc_plus4,
`ifdef IFU_INSTRET_CNT_EN
    output logic        fetch_err,
    output logic [31:0] instret_count
`else
    output logic        fetch_err
`endif
);

    typedef enum logic {FETCH, EXEC} state_t;

    localparam int CW = (ACK_TIMEOUT > 0) ? $clog2(ACK_TIMEOUT + 1) : 1;

    state_t               state;
    logic        [CW-1:0] wait_cnt;
    logic                 timed_out;
    logic                 take;
    logic signed [31:0]   br_off;
    logic        [31:0]   next_pc;

    assign opcode    = instr[31:26];
    assign pc_plus4  = pc + 32'd4;
    assign imem_addr = pc;

    // A zero ACK_TIMEOUT disables the timeout path entirely.
    assign timed_out = (ACK_TIMEOUT > 0) && (wait_cnt == CW'(ACK_TIMEOUT));

    always_comb begin
        // BNE inverts the sense of the zero flag; every other branch uses it directly.
        take    = (opcode == 6'b000101) ? ~zero : zero;
        br_off  = signed'(imm_ext) <<< 2;
        next_pc = pc_plus4;
        if (jump)
            next_pc = {pc_plus4[31:28], instr[25:0], 2'b00};
        else if (branch && take)
            next_pc = pc_plus4 + 32'(br_off);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= FETCH;
            pc          <= RESET_PC;
            instr       <= 32'h0;
            instr_valid <= 1'b0;
            imem_req    <= 1'b0;
            fetch_err   <= 1'b0;
            wait_cnt    <= '0;
`ifdef IFU_INSTRET_CNT_EN
            instret_count <= 32'h0;
`endif
        end else begin
            case (state)
                FETCH: begin
                    // Request is raised one cycle after reset release, so an
                    // ack that straddles reset is never mistaken for a response.
                    if (!imem_req) begin
                        imem_req <= 1'b1;
                    end else if (imem_ack) begin
                        instr       <= imem_rdata;
                        instr_valid <= 1'b1;
                        imem_req    <= 1'b0;
                        state       <= EXEC;
                    end else if (timed_out) begin
                        // Substitute a NOP so the pipeline keeps moving.
                        instr       <= 32'h0;
                        instr_valid <= 1'b1;
                        fetch_err   <= 1'b1;
                        imem_req    <= 1'b0;
                        state       <= EXEC;
                    end else if (ACK_TIMEOUT > 0) begin
                        wait_cnt <= wait_cnt + 1'b1;
                    end
                end
                EXEC: begin
                    if (advance) begin
                        pc          <= next_pc;
                        instr_valid <= 1'b0;
                        imem_req    <= 1'b1;
                        wait_cnt    <= '0;
                        state       <= FETCH;
`ifdef IFU_INSTRET_CNT_EN
                        instret_count <= instret_count + 32'd1;
`endif
                    end
                end
                default: state <= FETCH;
            endcase
        end
    end

endmodule

// File: tb/tb_instr_fetch_unit.sv
module tb_instr_fetch_unit;

    localparam logic [31:0] RST_PC = 32'h0000_0000;
    localparam int          TO     = 4;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ack = 1'b0;
    logic [31:0] imem_rdata = 32'h0;
    logic [31:0] instr;
    logic [5:0]  opcode;
    logic        instr_valid;
    logic        advance = 1'b0;
    logic        branch = 1'b0;
    logic        jump = 1'b0;
    logic        zero = 1'b0;
    logic [31:0] imm_ext = 32'h0;
    logic [31:0] pc;
    logic [31:0] pc_plus4;
    logic        fetch_err;
`ifdef IFU_INSTRET_CNT_EN
    logic [31:0] instret_count;
`endif

    instr_fetch_unit #(.RESET_PC(RST_PC), .ACK_TIMEOUT(TO)) dut (
        .clk(clk), .rst_n(rst_n),
        .imem_req(imem_req), .imem_addr(imem_addr),
        .imem_ack(imem_ack), .imem_rdata(imem_rdata),
        .instr(instr), .opcode(opcode), .instr_valid(instr_valid),
        .advance(advance), .branch(branch), .jump(jump), .zero(zero),
        .imm_ext(imm_ext), .pc(pc), .pc_plus4(pc_plus4),
`ifdef IFU_INSTRET_CNT_EN
        .fetch_err(fetch_err), .instret_count(instret_count)
`else
        .fetch_err(fetch_err)
`endif
    );

    always #5 clk = ~clk;

    int tests = 0;
    int fails = 0;

    // Transaction-level model of the architectural state.
    logic [31:0] m_pc = RST_PC;
    logic [31:0] m_instr = 32'h0;
    logic [31:0] m_cnt = 32'h0;
    logic        m_valid = 1'b0;
    logic        m_err = 1'b0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [31:0] model_next(input logic [31:0] cur_pc, input logic [31:0] ins,
                                               input logic br, input logic jp, input logic z,
                                               input logic [31:0] imm);
        logic [31:0] p4;
        logic        tk;
        p4 = cur_pc + 32'd4;
        if (jp) return {p4[31:28], ins[25:0], 2'b00};
        tk = (ins[31:26] == 6'd5) ? !z : z;
        if (br && tk) return p4 + imm * 32'd4;
        return p4;
    endfunction

    // Per-cycle comparison against the model, away from the active edge.
    always @(negedge clk) begin
        chk("pc", pc, m_pc);
        chk("pc_plus4", pc_plus4, m_pc + 32'd4);
        chk("imem_addr", imem_addr, m_pc);
        chk("fetch_err", {31'h0, fetch_err}, {31'h0, m_err});
        chk("instr_valid", {31'h0, instr_valid}, {31'h0, m_valid});
        if (m_valid) begin
            chk("instr", instr, m_instr);
            chk("opcode", {26'h0, opcode}, {26'h0, m_instr[31:26]});
            chk("req_in_exec", {31'h0, imem_req}, 32'h0);
        end
`ifdef IFU_INSTRET_CNT_EN
        chk("instret", instret_count, m_cnt);
`endif
    end

    task automatic model_reset();
        m_pc = RST_PC; m_instr = 32'h0; m_cnt = 32'h0; m_valid = 1'b0; m_err = 1'b0;
    endtask

    // Serve one fetch; waitn > TO means the memory never answers.
    task automatic do_fetch(input int waitn, input logic [31:0] data);
        int g = 0;
        while (imem_req !== 1'b1 && g < 8) begin
            @(posedge clk); #1;
            g++;
        end
        chk("req_rise", {31'h0, imem_req}, 32'd1);
        if (imem_req !== 1'b1) return;
        if (waitn > TO) begin
            repeat (TO + 1) begin
                chk("req_hold", {31'h0, imem_req}, 32'd1);
                advance = 1'($urandom);
                @(posedge clk); #1;
            end
            advance = 1'b0;
            m_instr = 32'h0; m_valid = 1'b1; m_err = 1'b1;
        end else begin
            repeat (waitn) begin
                chk("req_hold", {31'h0, imem_req}, 32'd1);
                advance = 1'($urandom);
                @(posedge clk); #1;
            end
            imem_ack = 1'b1; imem_rdata = data; advance = 1'($urandom);
            @(posedge clk); #1;
            imem_ack = 1'b0; advance = 1'b0; imem_rdata = $urandom;
            m_instr = data; m_valid = 1'b1;
        end
    endtask

    // Hold in EXEC for idle cycles with stray acks, then commit.
    task automatic do_exec(input logic br, input logic jp, input logic z,
                           input logic [31:0] imm, input int idle);
        logic [31:0] nxt;
        repeat (idle) begin
            imem_ack = 1'($urandom); imem_rdata = $urandom;
            @(posedge clk); #1;
        end
        imem_ack = 1'b0;
        branch = br; jump = jp; zero = z; imm_ext = imm; advance = 1'b1;
        nxt = model_next(m_pc, m_instr, br, jp, z, imm);
        @(posedge clk); #1;
        advance = 1'b0; branch = 1'b0; jump = 1'b0;
        m_pc = nxt; m_valid = 1'b0; m_cnt = m_cnt + 32'd1;
    endtask

    task automatic goto40();
        do_fetch(0, 32'h0800_0010);
        do_exec(1'b0, 1'b1, 1'b0, 32'h0, 0);
    endtask

    task automatic rand_step();
        logic [31:0] r, ins, imm;
        logic [5:0]  op;
        int          w;
        r = $urandom;
        case ($urandom % 5)
            0: op = 6'h08;
            1: op = 6'h04;
            2: op = 6'h05;
            3: op = 6'h02;
            default: op = 6'($urandom);
        endcase
        ins = {op, r[25:0]};
        w = ($urandom % 10 == 0) ? 6 : int'($urandom % 5);
        do_fetch(w, ins);
        r = $urandom;
        imm = {{16{r[15]}}, r[15:0]};
        do_exec(1'($urandom), 1'($urandom), 1'($urandom), imm, int'($urandom % 3));
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation still running, expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        repeat (3) @(posedge clk);
        #1;
        chk("rst_req", {31'h0, imem_req}, 32'h0);
        chk("rst_pc", pc, 32'h0);
        chk("rst_pc4", pc_plus4, 32'h4);
        chk("rst_instr", instr, 32'h0);
        chk("rst_valid", {31'h0, instr_valid}, 32'h0);
        chk("rst_err", {31'h0, fetch_err}, 32'h0);
        rst_n = 1'b1;

        // Directed: ADDI after two wait cycles
        do_fetch(2, 32'h2008_0005);
        chk("t1_opcode", {26'h0, opcode}, 32'h08);
        chk("t1_valid", {31'h0, instr_valid}, 32'd1);
        chk("t1_instr", instr, 32'h2008_0005);
        do_exec(1'b0, 1'b0, 1'b0, 32'h0, 0);
        chk("t1_pc", pc, 32'h4);

        // BEQ taken / not taken at 0x40
        goto40();
        chk("goto_pc", pc, 32'h40);
        do_fetch(1, 32'h1000_FFFE);
        do_exec(1'b1, 1'b0, 1'b1, 32'hFFFF_FFFE, 1);
        chk("t2_beq_taken", imem_addr, 32'h3C);
        goto40();
        do_fetch(0, 32'h1000_FFFE);
        do_exec(1'b1, 1'b0, 1'b0, 32'hFFFF_FFFE, 0);
        chk("t2_beq_not", imem_addr, 32'h44);

        // BNE taken / not taken
        goto40();
        do_fetch(0, 32'h1400_0003);
        do_exec(1'b1, 1'b0, 1'b0, 32'h3, 0);
        chk("t3_bne_taken", imem_addr, 32'h50);
        goto40();
        do_fetch(3, 32'h1400_0003);
        do_exec(1'b1, 1'b0, 1'b1, 32'h3, 2);
        chk("t3_bne_not", imem_addr, 32'h44);

        // Far branch into 0x1000_0000, then JAL with branch also high
        goto40();
        do_fetch(0, 32'h1000_0000);
        do_exec(1'b1, 1'b0, 1'b1, 32'h03FF_FFEF, 0);
        chk("t4_far", pc, 32'h1000_0000);
        do_fetch(0, 32'h0C00_0010);
        chk("t4_link", pc_plus4, 32'h1000_0004);
        do_exec(1'b1, 1'b1, 1'b1, 32'h5, 0);
        chk("t4_jal", pc, 32'h1000_0040);

        // Wrap at the top of the address space
        do_fetch(0, 32'h1000_0000);
        do_exec(1'b1, 1'b0, 1'b1, 32'h3BFF_FFEE, 0);
        chk("wrap_top", pc, 32'hFFFF_FFFC);
        chk("wrap_pc4", pc_plus4, 32'h0);
        do_fetch(0, 32'h2008_0001);
        do_exec(1'b0, 1'b0, 1'b0, 32'h0, 0);
        chk("wrap_zero", pc, 32'h0);

        // Ack exactly at the timeout boundary still wins
        do_fetch(TO, 32'h2008_0007);
        chk("edge_err", {31'h0, fetch_err}, 32'h0);
        chk("edge_instr", instr, 32'h2008_0007);
        do_exec(1'b0, 1'b0, 1'b0, 32'h0, 0);

        // Timeout inserts NOP and sets sticky error
        do_fetch(10, 32'hFFFF_FFFF);
        chk("t5_instr", instr, 32'h0);
        chk("t5_valid", {31'h0, instr_valid}, 32'd1);
        chk("t5_err", {31'h0, fetch_err}, 32'd1);
        do_exec(1'b0, 1'b0, 1'b0, 32'h0, 0);
        do_fetch(1, 32'h2008_0002);
        chk("t5_sticky", {31'h0, fetch_err}, 32'd1);
        do_exec(1'b0, 1'b0, 1'b0, 32'h0, 0);

        for (int i = 0; i < 150; i++) rand_step();

        // Reset in the middle of an outstanding fetch, ack arrives late
        do_fetch(0, 32'h2008_0003);
        do_exec(1'b0, 1'b0, 1'b0, 32'h0, 0);
        @(posedge clk); #1;
        rst_n = 1'b0;
        model_reset();
        #1;
        chk("t6_req", {31'h0, imem_req}, 32'h0);
        chk("t6_pc", pc, RST_PC);
        imem_ack = 1'b1; imem_rdata = 32'hDEAD_BEEF;
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(posedge clk); #1;
        imem_ack = 1'b0;
        chk("t6_late_valid", {31'h0, instr_valid}, 32'h0);
        chk("t6_late_instr", instr, 32'h0);

        for (int i = 0; i < 3; i++) begin
            do_fetch(i, 32'h2008_0000 + 32'(i));
            do_exec(1'b0, 1'b0, 1'b0, 32'h0, 0);
        end
        chk("t6_pc3", pc, RST_PC + 32'd12);
`ifdef IFU_INSTRET_CNT_EN
        chk("cnt_three", instret_count, 32'd3);
`endif
        @(posedge clk); #1;
        rst_n = 1'b0;
        model_reset();
        #1;
`ifdef IFU_INSTRET_CNT_EN
        chk("cnt_reset", instret_count, 32'd0);
`endif
        chk("t6_pc_again", pc, RST_PC);
        @(posedge clk); #1;
        rst_n = 1'b1;

        for (int i = 0; i < 30; i++) rand_step();

        @(posedge clk); #1;
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
